// File: rtl/sub_pkg.sv
// Shared types and helpers for the serial subtractor slice.
package sub_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sub_state_t;

    // Width of the digit counter; never narrower than one bit.
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/subtractor_1.sv
// One-bit full subtractor cell: d = a - b - Bin with borrow out.
module subtractor_1 (
    input  logic a,
    input  logic b,
    input  logic Bin,
    output logic d,
    output logic Bout
);

    assign d    = a ^ b ^ Bin;
    assign Bout = (~a & b) | (~(a ^ b) & Bin);

endmodule

// File: rtl/serial_subtractor_n.sv
// Multi-cycle N-bit subtractor D = a - b - Bin, DIGIT bits per clock, LSB first.
// Handshake: a beat transfers on a rising edge where valid && ready are both high.
module serial_subtractor_n
    import sub_pkg::*;
#(
    parameter int N     = 32,
    parameter int DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] D,
    output logic         Bout,
    output logic         overflow,
    output logic         zero,
    output logic         busy,
    output sub_state_t   dbg_state
);

    localparam int STEPS = N / DIGIT;
    localparam int CW    = cnt_width(STEPS);

    if (N % DIGIT != 0) begin : g_param_check
        $error("serial_subtractor_n: N must be a multiple of DIGIT");
    end

    sub_state_t     state, next_state;
    logic [N-1:0]   a_sh, b_sh, d_reg, d_next;
    logic [CW-1:0]  cnt;
    logic           borrow, a_msb, b_msb;
    logic           bout_r, ovf_r, zero_r;
    logic           last;
    logic [DIGIT-1:0] dig;
    logic [DIGIT:0]   bc;

    // Borrow ripples through the DIGIT cells within one clock.
    assign bc[0] = borrow;
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        subtractor_1 u_cell (
            .a    (a_sh[i]),
            .b    (b_sh[i]),
            .Bin  (bc[i]),
            .d    (dig[i]),
            .Bout (bc[i+1])
        );
    end

    // New difference digit enters from the MSB side.
    assign d_next = N'({dig, d_reg} >> DIGIT);
    assign last   = (state == S_RUN) && (cnt == CW'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) next_state = S_RUN;
            end
            S_RUN: begin
                if (last) next_state = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            d_reg  <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                a_sh   <= a;
                b_sh   <= b;
                borrow <= Bin;
                cnt    <= '0;
                a_msb  <= a[N-1];
                b_msb  <= b[N-1];
            end else if (state == S_RUN) begin
                a_sh   <= a_sh >> DIGIT;
                b_sh   <= b_sh >> DIGIT;
                borrow <= bc[DIGIT];
                cnt    <= cnt + CW'(1);
                d_reg  <= d_next;
                // Flags are only meaningful once the last digit is in.
                if (last) begin
                    bout_r <= bc[DIGIT];
                    ovf_r  <= (a_msb != b_msb) && (d_next[N-1] != a_msb);
                    zero_r <= ~|d_next;
                end
            end
        end
    end

    assign D         = d_reg;
    assign Bout      = bout_r;
    assign overflow  = ovf_r;
    assign zero      = zero_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_subtractor_n.sv
// Self-checking bench for serial_subtractor_n (N=8 with DIGIT=1 and DIGIT=4).
module tb_serial_subtractor_n;
    import sub_pkg::*;

    logic clk, rst_n;
    logic in_valid, in_ready, Bin, out_valid, out_ready, Bout, overflow, zero, busy;
    logic [7:0] a, b, D;
    sub_state_t dbg_state;

    logic in_valid4, in_ready4, Bin4, out_valid4, out_ready4, Bout4, overflow4, zero4, busy4;
    logic [7:0] a4, b4, D4;
    sub_state_t dbg_state4;

    logic [10:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    bit hold = 1'b0;
    bit rand_ready = 1'b0;

    serial_subtractor_n #(.N(8), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
        .D(D), .Bout(Bout), .overflow(overflow), .zero(zero), .busy(busy),
        .dbg_state(dbg_state)
    );

    serial_subtractor_n #(.N(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .Bin(Bin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .D(D4), .Bout(Bout4), .overflow(overflow4), .zero(zero4), .busy(busy4),
        .dbg_state(dbg_state4)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference: plain integer arithmetic, returns {D, Bout, overflow, zero}.
    function automatic logic [10:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic bi);
        int u, s;
        logic [7:0] d;
        logic bo, ov;
        u  = int'(x) - int'(y) - int'(bi);
        d  = u[7:0];
        bo = (u < 0);
        s  = int'($signed(x)) - int'($signed(y)) - int'(bi);
        ov = (s < -128) || (s > 127);
        return {d, bo, ov, (d == 8'h00)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic bi);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = x;
        b = y;
        Bin = bi;
        exp_q.push_back(ref_sub(x, y, bi));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        Bin = 1'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // consumer ready: changes just after the rising edge, away from monitor sampling
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = hold ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // scoreboard monitor
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'({D, Bout, overflow, zero}), 32'(e));
                end
            end
        end
    end

    logic [7:0] da[5] = '{8'h05, 8'h00, 8'h10, 8'h80, 8'h7F};
    logic [7:0] db[5] = '{8'h03, 8'h01, 8'h0F, 8'h01, 8'hFF};
    logic       dbin[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [10:0] snap;
        logic [10:0] e4;
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; Bin = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; Bin4 = 1'b0; out_ready4 = 1'b1;
        #22;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_D", 32'(D), 32'd0);
        check("rst_flags", 32'({Bout, overflow, zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // latency on the first directed op: out_valid rises exactly 8 edges after accept
        issue(da[0], db[0], dbin[0]);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 7) check("latency_before", 32'(out_valid), 32'd0);
            if (k == 8) check("latency_at", 32'(out_valid), 32'd1);
        end
        for (int i = 1; i < 5; i++) issue(da[i], db[i], dbin[i]);
        wait_drain();

        // hold in DONE: outputs stable, input side closed, in_valid pulses ignored
        hold = 1'b1;
        issue(8'h80, 8'h01, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("hold_reach_done", 32'(out_valid), 32'd1);
        snap = {D, Bout, overflow, zero};
        check("hold_value", 32'(snap), 32'(ref_sub(8'h80, 8'h01, 1'b0)));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("hold_stable", 32'({D, Bout, overflow, zero}), 32'(snap));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        hold = 1'b0;
        wait_drain();

        // asynchronous reset on the third RUN cycle
        issue(8'($urandom), 8'($urandom), 1'($urandom));
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h5A, 8'h3C, 1'b1);
        wait_drain();

        // DIGIT=4 instance: two-cycle latency and directed value
        @(negedge clk);
        in_valid4 = 1'b1; a4 = 8'h3C; b4 = 8'h5A; Bin4 = 1'b0;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        @(posedge clk);
        #1;
        check("d4_latency_before", 32'(out_valid4), 32'd0);
        @(posedge clk);
        #1;
        check("d4_latency_at", 32'(out_valid4), 32'd1);
        check("d4_result", 32'({D4, Bout4, overflow4, zero4}), 32'({8'hE2, 1'b1, 1'b0, 1'b0}));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n = 0;
            while (!in_ready4 && n < 20) begin
                @(negedge clk);
                n++;
            end
            in_valid4 = 1'b1; a4 = 8'($urandom); b4 = 8'($urandom); Bin4 = 1'($urandom);
            e4 = ref_sub(a4, b4, Bin4);
            @(posedge clk);
            #1;
            in_valid4 = 1'b0;
            n = 0;
            while (!out_valid4 && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("d4_random", 32'({out_valid4, D4, Bout4, overflow4, zero4}), 32'({1'b1, e4}));
        end

        // randomized traffic with random consumer back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) issue(8'($urandom), 8'($urandom), 1'($urandom));
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
